// File: rtl/tetris_processor_cpu_debug_ocimem_pkg.sv
// Shared definitions for the OCI debug-memory controller: FSM encoding,
// JTAG data-word field positions and the default access timeout.
package tetris_processor_cpu_debug_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } ocimem_state_t;

  localparam int JDO_W           = 38;
  localparam int JDO_ADDR_LSB    = 26;
  localparam int JDO_RD_BIT      = 34;
  localparam int JDO_CLRERR_BIT  = 35;
  localparam int JDO_WDATA_LSB   = 3;
  localparam int DATA_W          = 32;
  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/tetris_processor_cpu_debug_ocimem_timer.sv
// Counts consecutive ACCESS cycles; expired is high during the TIMEOUT-th
// cycle of a run, so the owner can abort at the end of that cycle.
module tetris_processor_cpu_debug_ocimem_timer
  import tetris_processor_cpu_debug_ocimem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  assign expired = run && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/tetris_processor_cpu_debug_ocimem_ctrl.sv
// JTAG-driven debug RAM access controller: loads address/data from jdo,
// performs one RAM read or write per command with ack timeout and error flag.
module tetris_processor_cpu_debug_ocimem_ctrl
  import tetris_processor_cpu_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: ram_req rises the cycle after a command strobe and holds,
  // with ram_we/ram_addr/ram_wdata stable, until the single-cycle ram_ack
  // (accepted only while ram_req is high) or until the timeout aborts it.

  ocimem_state_t state, state_next;

  logic any_strobe;
  logic start, start_we;
  logic load_addr, load_wdata;
  logic clr_err, set_err, clr_ready, set_ready;
  logic ack_fire;
  logic expired;
  logic unused_jdo_bits;

  assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  tetris_processor_cpu_debug_ocimem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_ACCESS),
    .run     (state == ST_ACCESS),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    start      = 1'b0;
    start_we   = 1'b0;
    load_addr  = 1'b0;
    load_wdata = 1'b0;
    clr_err    = 1'b0;
    set_err    = 1'b0;
    clr_ready  = 1'b0;
    set_ready  = 1'b0;
    ack_fire   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Strobe priority a > b > no_action; losers in the same cycle are dropped.
        if (take_action_ocimem_a) begin
          load_addr = 1'b1;
          clr_ready = 1'b1;
          clr_err   = jdo[JDO_CLRERR_BIT];
          start     = jdo[JDO_RD_BIT];
        end else if (take_action_ocimem_b) begin
          load_wdata = 1'b1;
          clr_ready  = 1'b1;
          start      = 1'b1;
          start_we   = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          clr_ready = 1'b1;
          start     = 1'b1;
        end
        if (start) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        set_err = any_strobe;
        if (ram_ack) begin
          ack_fire   = 1'b1;
          state_next = ST_DONE;
        end else if (expired) begin
          set_err    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        set_err    = any_strobe;
        set_ready  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      ram_we        <= 1'b0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      state <= state_next;
      if (start) ram_we <= start_we;
      if (load_addr) MonAReg <= jdo[JDO_ADDR_LSB +: ADDR_W];
      if (load_wdata) MonDReg <= jdo[JDO_WDATA_LSB +: DATA_W];
      if (ack_fire) begin
        if (!ram_we) MonDReg <= ram_rdata;
        MonAReg <= MonAReg + ADDR_W'(1);
      end
      if (set_ready) monitor_ready <= 1'b1;
      else if (clr_ready) monitor_ready <= 1'b0;
      if (set_err) monitor_error <= 1'b1;
      else if (clr_err) monitor_error <= 1'b0;
    end
  end

  assign ram_req   = (state == ST_ACCESS);
  assign ram_addr  = MonAReg;
  assign ram_wdata = MonDReg;
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule
